// File: rtl/dht11_pkg.sv
// Shared types for the DHT11 measurement sampler: FSM states, error codes,
// the captured reading payload and the double-dabble digit adjust.
package dht11_pkg;

  localparam int unsigned BIN_W       = 8;
  localparam int unsigned BCD_W       = 12;
  localparam int unsigned ERR_CNT_W   = 8;
  localparam int unsigned ERR_CNT_MAX = 255;

  typedef enum logic [2:0] {
    ST_STARTUP     = 3'd0,
    ST_WAIT_PERIOD = 3'd1,
    ST_TRIGGER     = 3'd2,
    ST_WAIT_DONE   = 3'd3,
    ST_CONVERT     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_t;

  typedef struct packed {
    logic [BIN_W-1:0] rh;
    logic [BIN_W-1:0] t;
  } reading_t;

  // Double-dabble correction applied to each BCD digit before a shift.
  function automatic logic [3:0] dabble_adj(input logic [3:0] d);
    return (d >= 4'd5) ? 4'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Sequential double-dabble: one load cycle, then eight shift cycles,
// converting an 8-bit binary value into three BCD digits.
module bin2bcd8
  import dht11_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  localparam int unsigned SH_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = 4;

  logic [SH_W-1:0]  shreg;
  logic [SH_W-1:0]  adj_c;
  logic [CNT_W-1:0] cnt;
  logic             run;

  always_comb begin
    adj_c = {dabble_adj(shreg[19:16]), dabble_adj(shreg[15:12]),
             dabble_adj(shreg[11:8]), shreg[7:0]};
  end

  // Load on start, then adjust-and-shift once per clock for BIN_W clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg <= {BCD_W'(0), bin};
        cnt   <= '0;
        run   <= 1'b1;
      end else if (run) begin
        shreg <= {adj_c[SH_W-2:0], 1'b0};
        cnt   <= CNT_W'(cnt + CNT_W'(1));
        if (cnt == CNT_W'(BIN_W - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign bcd = shreg[SH_W-1:BIN_W];

endmodule

// File: rtl/dht11_sampler.sv
// Periodic DHT11 measurement scheduler: triggers the bus controller on a
// fixed cadence, validates the result, converts it to BCD and tracks errors.
module dht11_sampler
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned STARTUP_MS = 1000,
  parameter int unsigned PERIOD_MS  = 2000,
  parameter int unsigned TIMEOUT_MS = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 dht11_done,
  input  logic                 dht11_valid,
  input  logic [BIN_W-1:0]     rh_data,
  input  logic [BIN_W-1:0]     t_data,
  output logic                 start,
  output logic [BCD_W-1:0]     rh_bcd,
  output logic [BCD_W-1:0]     t_bcd,
  output logic                 data_ready,
  output logic                 have_data,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           last_err,
  output logic                 busy
);

  localparam int unsigned TICK_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MS_MAX   = (STARTUP_MS > PERIOD_MS) ? STARTUP_MS : PERIOD_MS;
  localparam int unsigned MS_W     = $clog2(MS_MAX + 1);

  state_t           state;
  state_t           state_nx;
  logic [PRE_W-1:0] pre_cnt;
  logic [MS_W-1:0]  ms_cnt;
  logic             period_due;
  reading_t         capture;
  logic             conv_start;
  logic [BCD_W-1:0] rh_conv;
  logic [BCD_W-1:0] t_conv;
  logic             rh_conv_done;
  logic             t_conv_done;

  logic tick_c;
  logic period_exp_c;
  logic due_c;
  logic startup_done_c;
  logic trig_c;
  logic cap_c;
  logic csum_c;
  logic tmo_c;
  logic conv_ok_c;
  logic fail_c;

  assign tick_c       = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign period_exp_c = tick_c && (ms_cnt == MS_W'(PERIOD_MS - 1));
  assign due_c        = period_due || period_exp_c;
  assign fail_c       = csum_c || tmo_c;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_STARTUP;
    else     state <= state_nx;
  end

  // Next-state and per-clock event strobes.
  always_comb begin
    state_nx       = state;
    startup_done_c = 1'b0;
    trig_c         = 1'b0;
    cap_c          = 1'b0;
    csum_c         = 1'b0;
    tmo_c          = 1'b0;
    conv_ok_c      = 1'b0;
    case (state)
      ST_STARTUP: begin
        if (tick_c && (ms_cnt == MS_W'(STARTUP_MS - 1))) begin
          startup_done_c = 1'b1;
          state_nx       = ST_WAIT_PERIOD;
        end
      end
      ST_WAIT_PERIOD: begin
        if (due_c && enable) begin
          trig_c   = 1'b1;
          state_nx = ST_TRIGGER;
        end
      end
      ST_TRIGGER: state_nx = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        // A done on the expiry clock still counts as an answer.
        if (dht11_done) begin
          if (dht11_valid) begin
            cap_c    = 1'b1;
            state_nx = ST_CONVERT;
          end else begin
            csum_c   = 1'b1;
            state_nx = ST_WAIT_PERIOD;
          end
        end else if (tick_c && (ms_cnt == MS_W'(TIMEOUT_MS - 1))) begin
          tmo_c    = 1'b1;
          state_nx = ST_WAIT_PERIOD;
        end
      end
      ST_CONVERT: begin
        if (rh_conv_done && t_conv_done) begin
          conv_ok_c = 1'b1;
          state_nx  = ST_WAIT_PERIOD;
        end
      end
      default: state_nx = ST_STARTUP;
    endcase
  end

  // ms prescaler and ms counter, both restarted on every trigger so the
  // period and the timeout are measured from the start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt    <= '0;
      ms_cnt     <= '0;
      period_due <= 1'b0;
    end else if (trig_c) begin
      pre_cnt    <= '0;
      ms_cnt     <= '0;
      period_due <= 1'b0;
    end else begin
      pre_cnt <= tick_c ? '0 : PRE_W'(pre_cnt + PRE_W'(1));
      if (tick_c && (ms_cnt != MS_W'(MS_MAX))) ms_cnt <= MS_W'(ms_cnt + MS_W'(1));
      if (startup_done_c || period_exp_c) period_due <= 1'b1;
    end
  end

  // Registered outputs, capture register and converter launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start      <= 1'b0;
      busy       <= 1'b0;
      data_ready <= 1'b0;
      have_data  <= 1'b0;
      rh_bcd     <= '0;
      t_bcd      <= '0;
      err_cnt    <= '0;
      last_err   <= ERR_NONE;
      capture    <= '0;
      conv_start <= 1'b0;
    end else begin
      start      <= trig_c;
      busy       <= (state_nx == ST_TRIGGER) || (state_nx == ST_WAIT_DONE) ||
                    (state_nx == ST_CONVERT);
      data_ready <= conv_ok_c;
      conv_start <= cap_c;
      if (cap_c) capture <= '{rh: rh_data, t: t_data};
      if (conv_ok_c) begin
        rh_bcd    <= rh_conv;
        t_bcd     <= t_conv;
        have_data <= 1'b1;
        last_err  <= ERR_NONE;
      end
      if (fail_c) begin
        last_err <= csum_c ? ERR_CSUM : ERR_TIMEOUT;
        if (err_cnt != ERR_CNT_W'(ERR_CNT_MAX)) err_cnt <= ERR_CNT_W'(err_cnt + ERR_CNT_W'(1));
      end
    end
  end

  bin2bcd8 u_rh_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (capture.rh),
    .bcd   (rh_conv),
    .done  (rh_conv_done)
  );

  bin2bcd8 u_t_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (capture.t),
    .bcd   (t_conv),
    .done  (t_conv_done)
  );

endmodule

// File: tb/tb_dht11_sampler.sv
// Directed bench for dht11_sampler with a 10-clock millisecond.
module tb_dht11_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        dht11_done;
  logic        dht11_valid;
  logic [7:0]  rh_data;
  logic [7:0]  t_data;
  logic        start;
  logic [11:0] rh_bcd;
  logic [11:0] t_bcd;
  logic        data_ready;
  logic        have_data;
  logic [7:0]  err_cnt;
  logic [1:0]  last_err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  dht11_sampler #(
    .CLK_HZ     (10_000),
    .STARTUP_MS (3),
    .PERIOD_MS  (20),
    .TIMEOUT_MS (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .dht11_done  (dht11_done),
    .dht11_valid (dht11_valid),
    .rh_data     (rh_data),
    .t_data      (t_data),
    .start       (start),
    .rh_bcd      (rh_bcd),
    .t_bcd       (t_bcd),
    .data_ready  (data_ready),
    .have_data   (have_data),
    .err_cnt     (err_cnt),
    .last_err    (last_err),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic wait_start(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (start) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("start_seen", 32'd0, 32'd1);
  endtask

  task automatic wait_ready(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (data_ready) begin
        k = i;
        break;
      end
    end
  endtask

  // Called on a negedge; presents done for exactly one clock.
  task automatic pulse_done(input logic v, input logic [7:0] rh, input logic [7:0] t);
    dht11_done  = 1'b1;
    dht11_valid = v;
    rh_data     = rh;
    t_data      = t;
    @(negedge clk);
    dht11_done  = 1'b0;
    dht11_valid = 1'b0;
  endtask

  task automatic scan_ready(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seen = seen | data_ready;
    end
  endtask

  initial begin
    int   t1, t2, t3, k, at;
    logic seen;

    rst = 1'b1; enable = 1'b1; dht11_done = 1'b0; dht11_valid = 1'b0;
    rh_data = 8'd0; t_data = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({start, rh_bcd, t_bcd, data_ready, have_data, err_cnt, last_err, busy}), 32'd0);
    rst = 1'b0;

    // First trigger after 3 ms of startup.
    wait_start(100, t1);
    check("first_start_window", 32'((t1 >= 29) && (t1 <= 31)), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
    @(negedge clk);
    check("start_one_clk", 32'(start), 32'd0);
    pulse_done(1'b1, 8'd45, 8'd23);
    wait_ready(20, k);
    check("ready_latency", 32'(k), 32'd10);
    check("rh_bcd_45", 32'(rh_bcd), 32'h045);
    check("t_bcd_23", 32'(t_bcd), 32'h023);
    check("have_data_set", 32'(have_data), 32'd1);
    check("last_err_none", 32'(last_err), 32'd0);
    check("busy_low_after_conv", 32'(busy), 32'd0);
    @(negedge clk);
    check("ready_one_clk", 32'(data_ready), 32'd0);

    // Checksum failure: counters bump, data retained, no ready pulse.
    wait_start(250, t2);
    check("period_200", 32'(t2 - t1), 32'd200);
    check("second_start_window", 32'((t2 >= 229) && (t2 <= 231)), 32'd1);
    @(negedge clk);
    pulse_done(1'b0, 8'd77, 8'd66);
    check("csum_err_cnt", 32'(err_cnt), 32'd1);
    check("csum_last_err", 32'(last_err), 32'd1);
    check("csum_busy_low", 32'(busy), 32'd0);
    scan_ready(12, seen);
    check("csum_no_ready", 32'(seen), 32'd0);
    check("csum_rh_kept", 32'(rh_bcd), 32'h045);
    check("csum_t_kept", 32'(t_bcd), 32'h023);

    // Timeout 50 clocks after the start pulse, then a late done is ignored.
    wait_start(250, t3);
    check("period_200_b", 32'(t3 - t2), 32'd200);
    repeat (49) @(negedge clk);
    check("tmo_not_yet", 32'({busy, last_err, err_cnt}), 32'({1'b1, 2'd1, 8'd1}));
    @(negedge clk);
    check("tmo_last_err", 32'(last_err), 32'd2);
    check("tmo_err_cnt", 32'(err_cnt), 32'd2);
    check("tmo_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    pulse_done(1'b1, 8'd99, 8'd99);
    scan_ready(12, seen);
    check("late_done_no_ready", 32'(seen), 32'd0);
    check("late_done_rh_kept", 32'(rh_bcd), 32'h045);
    check("late_done_err_kept", 32'(last_err), 32'd2);

    // Full-scale and zero readings.
    wait_start(250, at);
    @(negedge clk);
    pulse_done(1'b1, 8'd255, 8'd0);
    wait_ready(20, k);
    check("ready_latency_b", 32'(k), 32'd10);
    check("rh_bcd_255", 32'(rh_bcd), 32'h255);
    check("t_bcd_0", 32'(t_bcd), 32'h000);
    check("ok_clears_last_err", 32'(last_err), 32'd0);
    check("ok_keeps_err_cnt", 32'(err_cnt), 32'd2);
    @(negedge clk);

    // enable low across expiry holds the trigger until enable returns.
    enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 230; i++) begin
      @(negedge clk);
      seen = seen | start;
    end
    check("no_start_disabled", 32'(seen), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    check("start_after_enable", 32'(start), 32'd1);
    @(negedge clk);
    pulse_done(1'b1, 8'd100, 8'd9);
    wait_ready(20, k);
    check("rh_bcd_100", 32'(rh_bcd), 32'h100);
    check("t_bcd_9", 32'(t_bcd), 32'h009);

    // 256 checksum failures: counter saturates at 255.
    for (int i = 0; i < 256; i++) begin
      wait_start(250, at);
      @(negedge clk);
      pulse_done(1'b0, 8'd1, 8'd1);
      if (i == 0)   check("sat_first", 32'(err_cnt), 32'd3);
      if (i == 252) check("sat_reach", 32'(err_cnt), 32'd255);
    end
    check("sat_hold", 32'(err_cnt), 32'd255);
    check("sat_last_err", 32'(last_err), 32'd1);
    check("sat_data_kept", 32'({have_data, rh_bcd, t_bcd}), 32'({1'b1, 12'h100, 12'h009}));

    // Reset in the middle of a conversion clears everything.
    wait_start(250, at);
    @(negedge clk);
    pulse_done(1'b1, 8'd12, 8'd34);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_conv_outs", 32'({start, rh_bcd, t_bcd, data_ready, have_data, err_cnt, last_err, busy}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    scan_ready(20, seen);
    check("rst_conv_no_ready", 32'(seen), 32'd0);
    check("rst_conv_cleared", 32'({have_data, err_cnt, last_err, rh_bcd}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dht11_sampler.md
# dht11_sampler

Periodic measurement scheduler and result formatter placed directly downstream of the DHT11 bus controller. Issues the controller's `start` pulse on a fixed cadence. Waits for `dht11_done` with a watchdog, then captures humidity and temperature only when the checksum is good. Converts both readings to 3-digit BCD for the FND display driver and keeps error statistics.

## Interface
- `CLK_HZ`, 100_000_000: clk frequency; sets the internal 1 ms tick (CLK_HZ/1000 clocks).
- `STARTUP_MS`, 1000: sensor settle time from reset release to the first trigger.
- `PERIOD_MS`, 2000: trigger-to-trigger interval. Constraint: > TIMEOUT_MS + 1.
- `TIMEOUT_MS`, 50: maximum wait for `dht11_done` after a trigger.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  allows new triggers; a measurement already in flight always completes.
- `dht11_done`  in  1  controller frame-complete pulse (≥1 clk).
- `dht11_valid`  in  1  controller checksum-good level; sampled together with done.
- `rh_data`  in  8  integer humidity from controller.
- `t_data`  in  8  integer temperature from controller.
- `start`  out  1  one-clock trigger to controller.
- `rh_bcd`  out  12  humidity as hundreds/tens/ones BCD.
- `t_bcd`  out  12  temperature as hundreds/tens/ones BCD.
- `data_ready`  out  1  one-clock pulse when `rh_bcd`/`t_bcd` update.
- `have_data`  out  1  sticky; set by the first successful reading.
- `err_cnt`  out  8  saturating count of failed measurements (stops at 255).
- `last_err`  out  2  0 = none, 1 = checksum, 2 = timeout; updated on every completed measurement.
- `busy`  out  1  high from `start` until return to WAIT_PERIOD.

## Operation
- Reset: all outputs 0. State = STARTUP. ms and period counters cleared.
- STARTUP: count STARTUP_MS ms ticks → WAIT_PERIOD with trigger due immediately.
- WAIT_PERIOD: when the period counter expires and `enable`=1 → TRIGGER.
  - If `enable`=0 at expiry, hold until `enable`=1, then trigger on the next clock.
  - `dht11_done` is ignored in this state.
- TRIGGER: `start`=1 for exactly one clock. Restart the period and timeout counters → WAIT_DONE.
- WAIT_DONE, `dht11_done`=1 and `dht11_valid`=1: capture `rh_data`/`t_data` → CONVERT.
- WAIT_DONE, `dht11_done`=1 and `dht11_valid`=0: `last_err`=1, `err_cnt`++, outputs retained → WAIT_PERIOD.
- WAIT_DONE, timeout expiry without done: `last_err`=2, `err_cnt`++ → WAIT_PERIOD.
- Done and timeout expiry on the same clock: done wins.
- CONVERT: run both `bin2bcd8` instances in parallel.
  - On their done: update `rh_bcd`/`t_bcd`, pulse `data_ready`, set `have_data`, `last_err`=0 → WAIT_PERIOD.
- Period is measured start-to-start, independent of outcome.
- Arithmetic: BCD digits are exact for 0–255; no clamping. `err_cnt` saturates and never wraps.
- `rst` mid-operation: immediate return to STARTUP with all outputs cleared, including `have_data`/`err_cnt`.

## Timing
- `start` pulse: 1 clk. Rising edges of `start` are exactly PERIOD_MS×CLK_HZ/1000 clocks apart while `enable`=1.
- First `start`: STARTUP_MS ms (±1 clk) after reset release.
- Capture edge = first rising edge sampling `dht11_done`=1 in WAIT_DONE (edge 0).
  - Converter load on edge 1, shift on edges 2–9.
  - `data_ready` high and new BCD values visible after edge 10. Latency 10 clocks.
- Error path: `err_cnt`/`last_err` update on the capture or timeout edge. `busy` falls on the same edge.
- Timeout expiry: TIMEOUT_MS ms ticks counted from the TRIGGER edge.

## Structure
- Package `dht11_pkg`: sampler state encoding (STARTUP, WAIT_PERIOD, TRIGGER, WAIT_DONE, CONVERT) and error codes (ERR_NONE = 0, ERR_CSUM = 1, ERR_TIMEOUT = 2).
- Sub-module `bin2bcd8`: sequential double-dabble, 8-bit in → 12-bit BCD out.
  - Ports: `clk`, `rst`, `start`, `bin[7:0]`, `bcd[11:0]`, `done`.
  - 1 load cycle plus 8 shift cycles; instantiated twice.
- ms tick generator and counters stay inline.

## Test plan
- CLK_HZ=10_000 (1 ms = 10 clk), STARTUP_MS=3, PERIOD_MS=20, TIMEOUT_MS=5; release reset → first `start` at clk 30 ± 1, second at clk 230.
- Done with valid=1, rh=45, t=23 → after 10 clk `rh_bcd`=0x045, `t_bcd`=0x023, `data_ready` 1 clk, `have_data`=1, `last_err`=0.
- Done with valid=0 → `err_cnt`=1, `last_err`=1, BCD outputs unchanged, no `data_ready`.
- No done for 50 clk after `start` → `last_err`=2, `err_cnt`++; a done arriving later in WAIT_PERIOD is ignored.
- rh=255, t=0 → `rh_bcd`=0x255, `t_bcd`=0x000. Force 256 failures → `err_cnt` holds at 255.
- `enable`=0 across the period expiry → no `start`; raise `enable` → `start` next clk. Assert `rst` during CONVERT → all outputs 0 and no `data_ready`.
